// File: rtl/addsub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: FSM encodings,
// mode constants and the signed-overflow helper.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Two's-complement overflow from the operand and result sign bits; for
  // subtraction the effective second operand is ~b.
  function automatic logic signed_ovf(input logic mode,
                                      input logic a_msb,
                                      input logic b_msb,
                                      input logic r_msb);
    logic b_eff;
    b_eff = b_msb ^ (mode == MODE_SUB);
    return (a_msb == b_eff) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/sub_digit.sv
// Combinational DIGIT-bit ripple slice: adds a_sl + (b_sl or ~b_sl) + cin.
// In subtract mode, the caller seeds cin with 1 to complete the two's complement.
module sub_digit
  import addsub_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_sl,
  input  logic [DIGIT-1:0] b_sl,
  input  logic             cin,
  input  logic             mode,
  output logic [DIGIT-1:0] sum_sl,
  output logic             cout
);

  always_comb begin
    logic c_v;
    logic be_v;
    c_v    = cin;
    be_v   = 1'b0;
    sum_sl = '0;
    for (int i = 0; i < DIGIT; i++) begin
      be_v      = b_sl[i] ^ (mode == MODE_SUB);
      sum_sl[i] = a_sl[i] ^ be_v ^ c_v;
      c_v       = (a_sl[i] & be_v) | (a_sl[i] & c_v) | (be_v & c_v);
    end
    cout = c_v;
  end

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial adder/subtractor processing DIGIT bits per cycle, LSB slice first.
// Define ADDSUB_SERIAL_OVF_EN to add the signed 'overflow' output.
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero
`ifdef ADDSUB_SERIAL_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               mode_q, mode_d;
  logic               carry_q, carry_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_out_q, carry_out_d;
  logic               zero_q, zero_d;
`ifdef ADDSUB_SERIAL_OVF_EN
  logic               a_msb_q, a_msb_d;
  logic               b_msb_q, b_msb_d;
  logic               overflow_q, overflow_d;
`endif

  logic [DIGIT-1:0]   sum_sl_s;
  logic               cout_s;
  logic [WIDTH-1:0]   a_shift_s;
  logic [WIDTH-1:0]   b_shift_s;
  logic [WIDTH-1:0]   acc_shift_s;

  sub_digit #(
    .DIGIT (DIGIT)
  ) u_sub_digit (
    .a_sl   (a_q[DIGIT-1:0]),
    .b_sl   (b_q[DIGIT-1:0]),
    .cin    (carry_q),
    .mode   (mode_q),
    .sum_sl (sum_sl_s),
    .cout   (cout_s)
  );

  // Operands shift right one slice per cycle; finished sum slices enter at the MSB end.
  if (DIGIT == WIDTH) begin : g_single
    assign a_shift_s   = '0;
    assign b_shift_s   = '0;
    assign acc_shift_s = sum_sl_s;
  end else begin : g_multi
    assign a_shift_s   = {{DIGIT{1'b0}}, a_q[WIDTH-1:DIGIT]};
    assign b_shift_s   = {{DIGIT{1'b0}}, b_q[WIDTH-1:DIGIT]};
    assign acc_shift_s = {sum_sl_s, acc_q[WIDTH-1:DIGIT]};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    mode_d      = mode_q;
    carry_d     = carry_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    zero_d      = zero_q;
`ifdef ADDSUB_SERIAL_OVF_EN
    a_msb_d     = a_msb_q;
    b_msb_d     = b_msb_q;
    overflow_d  = overflow_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          mode_d  = mode;
          acc_d   = '0;
          cnt_d   = '0;
          // Carry seeded with 1 for subtraction, i.e. borrow cleared.
          carry_d = (mode == MODE_SUB);
`ifdef ADDSUB_SERIAL_OVF_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = a_shift_s;
        b_d     = b_shift_s;
        acc_d   = acc_shift_s;
        carry_d = cout_s;
        if (cnt_q == CNT_LAST) begin
          cnt_d       = '0;
          result_d    = acc_shift_s;
          carry_out_d = cout_s ^ (mode_q == MODE_SUB);
          zero_d      = (acc_shift_s == '0);
`ifdef ADDSUB_SERIAL_OVF_EN
          overflow_d  = signed_ovf(mode_q, a_msb_q, b_msb_q, acc_shift_s[WIDTH-1]);
`endif
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == IDLE);
    // The done pulse trails the DONE state by one cycle, landing N+1 edges after acceptance.
    done_d  = (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      mode_q      <= MODE_ADD;
      carry_q     <= 1'b0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      zero_q      <= 1'b1;
`ifdef ADDSUB_SERIAL_OVF_EN
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      overflow_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      mode_q      <= mode_d;
      carry_q     <= carry_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      zero_q      <= zero_d;
`ifdef ADDSUB_SERIAL_OVF_EN
      a_msb_q     <= a_msb_d;
      b_msb_q     <= b_msb_d;
      overflow_q  <= overflow_d;
`endif
    end
  end

  assign ready     = ready_q;
  assign done      = done_q;
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign zero      = zero_q;
`ifdef ADDSUB_SERIAL_OVF_EN
  assign overflow  = overflow_q;
`endif

endmodule

// File: tb/tb_addsub_serial.sv
// Bench for addsub_serial: 8-bit/4-digit directed table and corner sequences,
// plus 32-bit DIGIT=1 and DIGIT=32 instances against a wide-arithmetic model.
module tb_addsub_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, mode;
  logic [7:0]  a, b, result8;
  logic        ready8, done8, carry8, zero8;
  logic        start32, mode32;
  logic [31:0] a32, b32, res_s, res_w;
  logic        ready_s, done_s, carry_s, zero_s;
  logic        ready_w, done_w, carry_w, zero_w;
`ifdef ADDSUB_SERIAL_OVF_EN
  logic        ovf8, ovf_s, ovf_w;
`endif

  int checks = 0;
  int errors = 0;

  addsub_serial #(.WIDTH(8), .DIGIT(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a), .b(b),
    .ready(ready8), .done(done8), .result(result8), .carry_out(carry8), .zero(zero8)
`ifdef ADDSUB_SERIAL_OVF_EN
    , .overflow(ovf8)
`endif
  );

  addsub_serial #(.WIDTH(32), .DIGIT(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start32), .mode(mode32), .a(a32), .b(b32),
    .ready(ready_s), .done(done_s), .result(res_s), .carry_out(carry_s), .zero(zero_s)
`ifdef ADDSUB_SERIAL_OVF_EN
    , .overflow(ovf_s)
`endif
  );

  addsub_serial #(.WIDTH(32), .DIGIT(32)) dut_w (
    .clk(clk), .rst_n(rst_n), .start(start32), .mode(mode32), .a(a32), .b(b32),
    .ready(ready_w), .done(done_w), .result(res_w), .carry_out(carry_w), .zero(zero_w)
`ifdef ADDSUB_SERIAL_OVF_EN
    , .overflow(ovf_w)
`endif
  );

  typedef struct {
    logic       m;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] r;
    logic       c;
    logic       z;
    logic       v;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [8:0] ref8(input logic m, input logic [7:0] x, input logic [7:0] y);
    return m ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
  endfunction

  // Issue one 8-bit op while scrambling operands during RUN; returns edges to done.
  task automatic run_op8(input logic m, input logic [7:0] x, input logic [7:0] y, output int lat);
    @(negedge clk);
    chk("ready_before_start", ready8, 1);
    start = 1'b1; mode = m; a = x; b = y;
    @(negedge clk);
    start = 1'b0; mode = ~m; a = ~x; b = ~y;
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (done8) begin
        lat = k;
        break;
      end
    end
  endtask

  int           lat, lat_s, lat_w, last_done, ndone, npush, nd_abort;
  logic [16:0]  pend[$];
  logic [16:0]  e;
  logic [8:0]   r9;
  logic [31:0]  x32, y32;
  logic         m32;
  logic [32:0]  e33;
  logic signed [33:0] s34;

  initial begin
    rst_n = 1'b0; start = 1'b1; mode = 1'b0; a = 8'h11; b = 8'h22;
    start32 = 1'b0; mode32 = 1'b0; a32 = 32'h0; b32 = 32'h0;

    vecs[0] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 8'h3C, 8'h3C, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 8'h55, 8'hAA, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0};

    // Reset held with start high: reset must win.
    repeat (2) @(negedge clk);
    rst_n = 1'b1; start = 1'b0;
    chk("rst_ready", ready8, 1);
    chk("rst_done", done8, 0);
    chk("rst_result", result8, 8'h00);
    chk("rst_carry", carry8, 0);
    chk("rst_zero", zero8, 1);
`ifdef ADDSUB_SERIAL_OVF_EN
    chk("rst_ovf", ovf8, 0);
`endif
    nd_abort = 0;
    repeat (4) begin
      @(negedge clk);
      if (done8) nd_abort++;
    end
    chk("rst_start_no_done", nd_abort, 0);

    for (int i = 0; i < 10; i++) begin
      run_op8(vecs[i].m, vecs[i].x, vecs[i].y, lat);
      chk("tbl_latency", lat, 3);
      chk("tbl_result", result8, vecs[i].r);
      chk("tbl_carry", carry8, vecs[i].c);
      chk("tbl_zero", zero8, vecs[i].z);
`ifdef ADDSUB_SERIAL_OVF_EN
      chk("tbl_ovf", ovf8, vecs[i].v);
`endif
      @(negedge clk);
      chk("tbl_done_pulse", done8, 0);
      chk("tbl_result_hold", result8, vecs[i].r);
    end

    // start held high with operands changing every cycle.
    last_done = -1; ndone = 0; npush = 0;
    for (int cyc = 0; cyc < 34; cyc++) begin
      @(negedge clk);
      if (done8) begin
        if (pend.size() == 0) begin
          chk("stream_unexpected_done", 1, 0);
        end else begin
          e  = pend.pop_front();
          r9 = ref8(e[16], e[15:8], e[7:0]);
          chk("stream_result", result8, r9[7:0]);
          chk("stream_carry", carry8, r9[8]);
        end
        if (last_done >= 0) chk("stream_gap", cyc - last_done, 4);
        last_done = cyc;
        ndone++;
      end
      start = (cyc < 24);
      mode  = ((cyc / 4) % 2) == 1;
      a     = 8'(cyc * 37 + 5);
      b     = 8'(cyc * 11 + 3);
      if (start && ready8) begin
        pend.push_back({mode, a, b});
        npush++;
      end
    end
    chk("stream_count", ndone, npush);

    // Reset for one cycle in the middle of RUN aborts the op.
    @(negedge clk);
    start = 1'b1; mode = 1'b0; a = 8'h55; b = 8'h11;
    @(negedge clk);
    start = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_ready", ready8, 1);
    chk("abort_result", result8, 8'h00);
    chk("abort_zero", zero8, 1);
    chk("abort_done", done8, 0);
    nd_abort = 0;
    repeat (6) begin
      @(negedge clk);
      if (done8) nd_abort++;
    end
    chk("abort_no_done", nd_abort, 0);
    run_op8(1'b0, 8'h12, 8'h34, lat);
    chk("post_abort_latency", lat, 3);
    chk("post_abort_result", result8, 8'h46);

    // 32-bit instances: DIGIT=1 (latency 33) and DIGIT=32 (latency 2).
    for (int i = 0; i < 12; i++) begin
      x32 = $urandom; y32 = $urandom; m32 = 1'($urandom_range(0, 1));
      if (i == 0) begin x32 = 32'hFFFF_FFFF; y32 = 32'h1; m32 = 1'b0; end
      if (i == 1) begin x32 = 32'h0; y32 = 32'h1; m32 = 1'b1; end
      if (i == 2) begin x32 = 32'h8000_0000; y32 = 32'h1; m32 = 1'b1; end
      e33 = m32 ? ({1'b0, x32} - {1'b0, y32}) : ({1'b0, x32} + {1'b0, y32});
      s34 = m32 ? ($signed({{2{x32[31]}}, x32}) - $signed({{2{y32[31]}}, y32}))
                : ($signed({{2{x32[31]}}, x32}) + $signed({{2{y32[31]}}, y32}));
      @(negedge clk);
      start32 = 1'b1; mode32 = m32; a32 = x32; b32 = y32;
      @(negedge clk);
      start32 = 1'b0; a32 = ~x32; b32 = ~y32;
      lat_s = -1; lat_w = -1;
      for (int k = 1; k <= 40; k++) begin
        @(negedge clk);
        if (done_w && lat_w < 0) begin
          lat_w = k;
          chk("w_result", res_w, e33[31:0]);
          chk("w_carry", carry_w, e33[32]);
          chk("w_zero", zero_w, e33[31:0] == 32'h0);
`ifdef ADDSUB_SERIAL_OVF_EN
          chk("w_ovf", ovf_w, s34[32] ^ s34[31]);
`endif
        end
        if (done_s && lat_s < 0) begin
          lat_s = k;
          chk("s_result", res_s, e33[31:0]);
          chk("s_carry", carry_s, e33[32]);
          chk("s_zero", zero_s, e33[31:0] == 32'h0);
`ifdef ADDSUB_SERIAL_OVF_EN
          chk("s_ovf", ovf_s, s34[32] ^ s34[31]);
`endif
        end
      end
      chk("w_latency", lat_w, 2);
      chk("s_latency", lat_s, 33);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/addsub_serial.md
ADDSUB_SERIAL -- requirements
Module: addsub_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter DIGIT, default 4, bits processed per cycle; WIDTH mod DIGIT = 0, DIGIT >= 1.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  request; accepted only when ready=1.
REQ-006 SHALL have port mode  input  1  0 = a+b, 1 = a-b; sampled with start.
REQ-007 SHALL have ports a, b  input  WIDTH  operands; sampled with start.
REQ-008 SHALL have port ready  output  1  high in IDLE only.
REQ-009 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-010 SHALL have port result  output  WIDTH  last completed sum/difference.
REQ-011 SHALL have port carry_out  output  1  add: carry out of MSB; sub: borrow (1 iff a < b unsigned).
REQ-012 SHALL have port zero  output  1  result == 0.

Function
REQ-013 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-014 IDLE: ready=1; start=1 latches a, b, mode, clears digit counter and carry/borrow, goes to RUN.
REQ-015 RUN: each cycle processes one DIGIT-bit slice, LSB slice first, ripple carry/borrow held in a register between slices.
REQ-016 RUN SHALL last exactly N = WIDTH/DIGIT cycles, then go to DONE.
REQ-017 DONE: done=1 for one cycle; result, carry_out, zero (and overflow) update on entry to DONE; then IDLE.
REQ-018 Latency: start accepted at edge t -> done high during the cycle after edge t+N+1; one op per N+2 cycles.
REQ-019 start while ready=0 SHALL be ignored, no queuing; operand changes during RUN SHALL have no effect.
REQ-020 result/flags SHALL hold their values from DONE until the next DONE; they SHALL NOT show partial values.
REQ-021 Arithmetic modulo 2^WIDTH; subtraction is a + ~b + 1, borrow = ~carry.
REQ-022 DIGIT = WIDTH SHALL be legal (N = 1).

Reset
REQ-023 rst_n=0 at an edge SHALL force IDLE, ready=1, done=0, result=0, carry_out=0, zero=1, overflow=0, counter=0.
REQ-024 Reset during RUN or DONE SHALL abort the op; no done pulse for it.
REQ-025 rst_n=0 SHALL override a simultaneous start.

Configuration
REQ-026 Macro ADDSUB_SERIAL_OVF_EN defined: output port overflow (1 bit) present, set on DONE to signed overflow (add: sign(a)=sign(b)!=sign(r); sub: sign(a)!=sign(b) and sign(r)!=sign(a)).
REQ-027 Macro undefined: no overflow port, no related logic; all other behaviour identical.

Structure
REQ-028 Shared package addsub_pkg SHALL hold FSM state encodings (IDLE, RUN, DONE) and mode constants (MODE_ADD=0, MODE_SUB=1).
REQ-029 Sub-module sub_digit SHALL be the combinational DIGIT-bit ripple slice (inputs slice a, slice b, cin, mode; outputs slice sum, cout), instantiated once.
REQ-030 Operand and result registers SHALL be shift registers shifting right by DIGIT per RUN cycle.

Verification
REQ-031 WIDTH=8, DIGIT=4: add 8'h7F + 8'h01 -> result 8'h80, carry_out 0, zero 0, overflow 1, done 3 cycles after start edge.
REQ-032 WIDTH=8, DIGIT=4: sub 8'h05 - 8'h07 -> 8'hFE, carry_out(borrow) 1, overflow 0; sub 8'h80 - 8'h01 -> 8'h7F, borrow 0, overflow 1.
REQ-033 WIDTH=8, DIGIT=4: sub 8'h3C - 8'h3C -> 8'h00, zero 1, borrow 0; add 8'hFF + 8'h01 -> 8'h00, carry_out 1, zero 1.
REQ-034 start held high continuously with changing operands -> only ops at ready=1 accepted, one done per N+2 cycles, results match operands sampled at acceptance.
REQ-035 rst_n low for one cycle mid-RUN -> ready=1 next cycle, result 0, zero 1, no done pulse; following add 8'h12 + 8'h34 -> 8'h46.
REQ-036 WIDTH=32, DIGIT=1 and WIDTH=32, DIGIT=32: random add/sub vs reference model, latency 33 and 2 cycles respectively; build with and without ADDSUB_SERIAL_OVF_EN.
